// File: rtl/divider_8bit_seq.sv
// rtl/divider_8bit_seq.sv - sequential restoring divider with a ripple-borrow subtractor core

module sub_ripple #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         cout
);
    // a + ~b + 1: carry-out high means no borrow
    logic [W:0] c;
    assign c[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff[i]  = a[i] ^ ~b[i] ^ c[i];
        assign c[i + 1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
    end

    assign cout = c[W];
endmodule

module divider_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             borrow;
    logic [WIDTH-1:0] r_d, q_d;

    assign p = {r_q, q_q[WIDTH-1]};

    sub_ripple #(.W(WIDTH)) u_sub (
        .a    (p[WIDTH-1:0]),
        .b    (d_q),
        .diff (diff),
        .cout (cout)
    );

    // A set top bit of P means P already exceeds any WIDTH-bit divisor
    assign borrow = ~cout & ~p[WIDTH];
    assign r_d    = borrow ? p[WIDTH-1:0] : diff;
    assign q_d    = {q_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        d_q <= divisor;
                        if (divisor != '0) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                            r_q     <= '0;
                            q_q     <= dividend;
                        end else begin
                            state_q     <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                        dbz_q       <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule
